// File: rtl/qpu_itcm_pkg.sv
// Shared types and defaults for the QPU instruction TCM controller.
// Holds the response-source and FSM state encodings plus a half-line select helper.
package qpu_itcm_pkg;

    localparam int          ITCM_AW_DEF   = 12;
    localparam logic [31:0] ITCM_BASE_DEF = 32'h8000_0000;

    typedef enum logic [1:0] {
        SRC_ERR,
        SRC_BUF,
        SRC_SRAM
    } src_e;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } state_e;

    function automatic logic [31:0] sel_half(input logic [63:0] line, input logic upper);
        return upper ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/qpu_itcm_if.sv
// IFU fetch REQ/RSP bus between the ifetch stage (master) and the ITCM controller (slave).
interface qpu_itcm_if #(
    parameter int PC_SIZE    = 32,
    parameter int INSTR_SIZE = 32
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [PC_SIZE-1:0]    ifu_req_pc;
    logic                  ifu_req_seq;
    logic                  ifu_rsp_valid;
    logic                  ifu_rsp_ready;
    logic [INSTR_SIZE-1:0] ifu_rsp_instr;
    logic                  ifu_rsp_err;

    modport master (
        output ifu_req_valid, ifu_req_pc, ifu_req_seq, ifu_rsp_ready,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err
    );

    modport slave (
        input  ifu_req_valid, ifu_req_pc, ifu_req_seq, ifu_rsp_ready,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err
    );
endinterface

// File: rtl/qpu_itcm_linebuf.sv
// One-line buffer of the most recently read ITCM line, used to serve sequential
// upper-half fetches without an SRAM access; writes to the buffered line invalidate it.
module qpu_itcm_linebuf
    import qpu_itcm_pkg::*;
#(
    parameter int AW = ITCM_AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_i,
    input  logic [AW-1:0] alloc_line_i,
    input  logic [63:0]   rdata_i,
    input  logic          wr_valid_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          lookup_seq_i,
    input  logic          lookup_half_i,
    input  logic [AW-1:0] lookup_line_i,
    output logic          hit_o,
    input  logic          rd_half_i,
    output logic [31:0]   rd_word_o
);

    logic [AW-1:0] tag_q, tag_d;
    logic          vld_q, vld_d;
    logic          fill_q, fill_d;
    logic [63:0]   data_q, data_d;

    // A fill in flight counts as valid: the data lands before the hitting
    // request's response cycle, and a write in between blocks that request.
    assign hit_o     = lookup_seq_i & lookup_half_i & (vld_q | fill_q) & (tag_q == lookup_line_i);
    assign rd_word_o = sel_half(data_q, rd_half_i);

    always_comb begin
        tag_d  = tag_q;
        vld_d  = vld_q;
        fill_d = 1'b0;
        data_d = data_q;
        if (fill_q) begin
            data_d = rdata_i;
            vld_d  = 1'b1;
        end
        if (wr_valid_i && (wr_addr_i == tag_q)) begin
            vld_d = 1'b0;
        end
        if (alloc_i) begin
            tag_d  = alloc_line_i;
            vld_d  = 1'b0;
            fill_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q  <= '0;
            vld_q  <= 1'b0;
            fill_q <= 1'b0;
            data_q <= '0;
        end else begin
            tag_q  <= tag_d;
            vld_q  <= vld_d;
            fill_q <= fill_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/qpu_itcm_ctrl.sv
// ITCM responder for QPU instruction fetch: decodes the PC, arbitrates program-load
// writes onto the single-port SRAM, and returns one instruction per request at N+1.
module qpu_itcm_ctrl
    import qpu_itcm_pkg::*;
#(
    parameter int                 PC_SIZE    = 32,
    parameter int                 INSTR_SIZE = 32,
    parameter int                 ITCM_AW    = ITCM_AW_DEF,
    parameter logic [PC_SIZE-1:0] ITCM_BASE  = ITCM_BASE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    qpu_itcm_if.slave          ifu,
    input  logic               ext_wr_valid,
    output logic               ext_wr_ready,
    input  logic [ITCM_AW-1:0] ext_wr_addr,
    input  logic [63:0]        ext_wr_data,
    input  logic [7:0]         ext_wr_mask,
    output logic               itcm_cs,
    output logic               itcm_we,
    output logic [ITCM_AW-1:0] itcm_addr,
    output logic [63:0]        itcm_wdata,
    output logic [7:0]         itcm_wem,
    input  logic [63:0]        itcm_rdata
);

    logic [ITCM_AW-1:0]    req_line;
    logic                  req_half;
    logic                  req_oor;
    logic                  req_misal;
    logic                  req_hsk;
    logic                  rsp_hsk;
    logic                  accept;
    logic                  sram_rd;
    logic                  lbuf_hit;
    logic [31:0]           lbuf_word;
    src_e                  req_src;

    state_e                state_q;
    src_e                  src_q;
    logic                  half_q;
    logic                  first_q;
    logic [INSTR_SIZE-1:0] hold_instr_q;
    logic                  hold_err_q;
    logic [INSTR_SIZE-1:0] first_instr;
    logic                  first_err;

    assign req_line  = ifu.ifu_req_pc[ITCM_AW+2:3];
    assign req_half  = ifu.ifu_req_pc[2];
    assign req_oor   = ifu.ifu_req_pc[PC_SIZE-1:ITCM_AW+3] != ITCM_BASE[PC_SIZE-1:ITCM_AW+3];
    assign req_misal = |ifu.ifu_req_pc[1:0];

    // Ready deliberately ignores rsp_ready so ifetch can close its loop combinationally.
    assign ifu.ifu_req_ready = ~ext_wr_valid;
    assign ext_wr_ready      = ext_wr_valid;

    assign req_hsk = ifu.ifu_req_valid & ifu.ifu_req_ready;
    assign rsp_hsk = (state_q == ST_RESP) & ifu.ifu_rsp_ready;
    // A request arriving while a response is stalled is dropped.
    assign accept  = ~rst & req_hsk & ((state_q == ST_IDLE) | rsp_hsk);

    always_comb begin
        req_src = SRC_SRAM;
        if (req_oor || req_misal) begin
            req_src = SRC_ERR;
        end else if (lbuf_hit) begin
            req_src = SRC_BUF;
        end
    end

    assign sram_rd    = accept & (req_src == SRC_SRAM);
    assign itcm_cs    = ~rst & (ext_wr_valid | sram_rd);
    assign itcm_we    = ~rst & ext_wr_valid;
    assign itcm_addr  = ext_wr_valid ? ext_wr_addr : req_line;
    assign itcm_wdata = ext_wr_data;
    assign itcm_wem   = ext_wr_mask;

    qpu_itcm_linebuf #(
        .AW (ITCM_AW)
    ) u_linebuf (
        .clk           (clk),
        .rst           (rst),
        .alloc_i       (sram_rd),
        .alloc_line_i  (req_line),
        .rdata_i       (itcm_rdata),
        .wr_valid_i    (itcm_we),
        .wr_addr_i     (ext_wr_addr),
        .lookup_seq_i  (ifu.ifu_req_seq),
        .lookup_half_i (req_half),
        .lookup_line_i (req_line),
        .hit_o         (lbuf_hit),
        .rd_half_i     (half_q),
        .rd_word_o     (lbuf_word)
    );

    always_comb begin
        first_instr = '0;
        first_err   = 1'b0;
        case (src_q)
            SRC_ERR:  first_err   = 1'b1;
            SRC_BUF:  first_instr = lbuf_word;
            SRC_SRAM: first_instr = sel_half(itcm_rdata, half_q);
            default:  first_err   = 1'b1;
        endcase
    end

    // Only the first response cycle looks at live data; stalls replay the hold register.
    assign ifu.ifu_rsp_valid = (state_q == ST_RESP);
    assign ifu.ifu_rsp_instr = first_q ? first_instr : hold_instr_q;
    assign ifu.ifu_rsp_err   = first_q ? first_err : hold_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            src_q        <= SRC_ERR;
            half_q       <= 1'b0;
            first_q      <= 1'b0;
            hold_instr_q <= '0;
            hold_err_q   <= 1'b0;
        end else begin
            if (first_q) begin
                hold_instr_q <= first_instr;
                hold_err_q   <= first_err;
            end
            first_q <= accept;
            if (accept) begin
                src_q  <= req_src;
                half_q <= req_half;
            end
            case (state_q)
                ST_IDLE: if (accept) state_q <= ST_RESP;
                ST_RESP: if (rsp_hsk && !accept) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qpu_itcm_ctrl.sv
// Bench for qpu_itcm_ctrl: directed vector table, multi-cycle corner sequences and a
// randomized run against a memory-level reference model with an expected-response queue.
module tb_qpu_itcm_ctrl;
    import qpu_itcm_pkg::*;

    localparam int          AW     = 12;
    localparam int          NLINES = 4096;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] LIMIT  = 32'h8000_8000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qpu_itcm_if #(.PC_SIZE(32), .INSTR_SIZE(32)) ifu_bus ();

    logic          ext_wr_valid;
    logic          ext_wr_ready;
    logic [AW-1:0] ext_wr_addr;
    logic [63:0]   ext_wr_data;
    logic [7:0]    ext_wr_mask;
    logic          itcm_cs;
    logic          itcm_we;
    logic [AW-1:0] itcm_addr;
    logic [63:0]   itcm_wdata;
    logic [7:0]    itcm_wem;
    logic [63:0]   itcm_rdata;

    qpu_itcm_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ifu          (ifu_bus.slave),
        .ext_wr_valid (ext_wr_valid),
        .ext_wr_ready (ext_wr_ready),
        .ext_wr_addr  (ext_wr_addr),
        .ext_wr_data  (ext_wr_data),
        .ext_wr_mask  (ext_wr_mask),
        .itcm_cs      (itcm_cs),
        .itcm_we      (itcm_we),
        .itcm_addr    (itcm_addr),
        .itcm_wdata   (itcm_wdata),
        .itcm_wem     (itcm_wem),
        .itcm_rdata   (itcm_rdata)
    );

    function automatic logic [63:0] init_line(input int l);
        logic [31:0] lo;
        lo = 32'h1000_0000 + 32'(l) * 32'd8;
        return {lo ^ 32'h3000_0004, lo};
    endfunction

    // Behavioural 1-cycle-latency SRAM, preloaded on its first clock.
    logic [63:0] sram [NLINES];
    bit          sram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!sram_loaded) begin
            for (int i = 0; i < NLINES; i++) sram[i] <= init_line(i);
            sram_loaded <= 1'b1;
        end else if (itcm_cs) begin
            if (itcm_we) begin
                for (int b = 0; b < 8; b++)
                    if (itcm_wem[b]) sram[itcm_addr][b*8 +: 8] <= itcm_wdata[b*8 +: 8];
            end else begin
                itcm_rdata <= sram[itcm_addr];
            end
        end
    end

    // Reference contents of the ITCM as seen by the program-load port.
    logic [63:0] ref_mem [NLINES];

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];

    typedef struct {
        logic [31:0] pc;
        logic        seq;
        logic        exp_cs;
        logic        exp_err;
        logic [31:0] exp_instr;
    } vec_t;
    vec_t vecs[13];

    function automatic rsp_t ref_rsp(input logic [31:0] pc);
        rsp_t r;
        int   line;
        int   half;
        r.err   = (pc < BASE) || (pc >= LIMIT) || (pc % 4 != 0);
        r.instr = 32'h0;
        if (!r.err) begin
            line = int'((pc - BASE) / 8);
            half = int'(((pc - BASE) / 4) % 2);
            r.instr = (half == 1) ? ref_mem[line][63:32] : ref_mem[line][31:0];
        end
        return r;
    endfunction

    task automatic apply_write(input int a, input logic [63:0] d, input logic [7:0] m);
        for (int b = 0; b < 8; b++)
            if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifu_bus.ifu_req_valid = 1'b0;
        ifu_bus.ifu_req_pc    = 32'h0;
        ifu_bus.ifu_req_seq   = 1'b0;
        ifu_bus.ifu_rsp_ready = 1'b1;
        ext_wr_valid          = 1'b0;
        ext_wr_addr           = '0;
        ext_wr_data           = 64'h0;
        ext_wr_mask           = 8'h0;
    endtask

    task automatic set_req(input logic [31:0] pc, input logic seq);
        ifu_bus.ifu_req_valid = 1'b1;
        ifu_bus.ifu_req_pc    = pc;
        ifu_bus.ifu_req_seq   = seq;
    endtask

    // The bench itself must never issue a request into a stalled response.
    always @(negedge clk) begin
        if (!rst)
            assert (!(ifu_bus.ifu_req_valid && ifu_bus.ifu_req_ready &&
                      ifu_bus.ifu_rsp_valid && !ifu_bus.ifu_rsp_ready))
            else $error("illegal request while response is stalled");
    end

    initial begin
        rsp_t        r;
        logic [31:0] old_word;
        logic [31:0] last_pc;
        logic [31:0] pc;
        logic        stalled;
        logic        acc;
        int          sel;

        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < NLINES; i++) ref_mem[i] = init_line(i);

        vecs[0]  = '{32'h8000_0010, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{32'h8000_0014, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{32'h8000_0014, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{32'h8000_0018, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{32'h8000_001C, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{32'h9000_0000, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{32'h8000_0002, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{32'h7FFF_FFFC, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{32'h8000_7FFC, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{32'h8000_8000, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[10] = '{32'h8000_0024, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{32'h8000_0024, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{32'h8000_0026, 1'b1, 1'b0, 1'b1, 32'h0};
        for (int i = 0; i < 13; i++) vecs[i].exp_instr = ref_rsp(vecs[i].pc).instr;

        // Reset state
        next_drive(); next_drive(); next_drive();
        to_sample();
        chk("reset_rsp_valid", ifu_bus.ifu_rsp_valid, 1'b0);
        chk("reset_rsp_err", ifu_bus.ifu_rsp_err, 1'b0);
        chk("reset_rsp_instr", ifu_bus.ifu_rsp_instr, 32'h0);
        chk("reset_cs", itcm_cs, 1'b0);
        chk("reset_req_ready", ifu_bus.ifu_req_ready, 1'b1);
        next_drive();
        rst = 1'b0;

        // Directed vector table: one request, response at N+1
        for (int i = 0; i < 13; i++) begin
            set_req(vecs[i].pc, vecs[i].seq);
            to_sample();
            chk($sformatf("vec%0d_req_ready", i), ifu_bus.ifu_req_ready, 1'b1);
            chk($sformatf("vec%0d_cs", i), itcm_cs, vecs[i].exp_cs);
            next_drive();
            ifu_bus.ifu_req_valid = 1'b0;
            to_sample();
            chk($sformatf("vec%0d_rsp_valid", i), ifu_bus.ifu_rsp_valid, 1'b1);
            chk($sformatf("vec%0d_err", i), ifu_bus.ifu_rsp_err, vecs[i].exp_err);
            chk($sformatf("vec%0d_instr", i), ifu_bus.ifu_rsp_instr, vecs[i].exp_instr);
            next_drive();
        end

        // Eight back-to-back requests complete in eight cycles
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) set_req(32'h8000_0040 + 32'(k) * 4, k > 0);
            else ifu_bus.ifu_req_valid = 1'b0;
            to_sample();
            if (k < 8) chk($sformatf("b2b%0d_cs", k), itcm_cs, (k % 2) == 0);
            if (k > 0) begin
                chk($sformatf("b2b%0d_rsp_valid", k), ifu_bus.ifu_rsp_valid, 1'b1);
                chk($sformatf("b2b%0d_instr", k), ifu_bus.ifu_rsp_instr,
                    ref_rsp(32'h8000_0040 + 32'(k - 1) * 4).instr);
            end
            next_drive();
        end
        to_sample();
        chk("b2b_done_idle", ifu_bus.ifu_rsp_valid, 1'b0);
        next_drive();

        // Stall hold with a concurrent write to the same line
        old_word = ref_rsp(32'h8000_0020).instr;
        set_req(32'h8000_0020, 1'b0);
        to_sample();
        chk("stall_req_cs", itcm_cs, 1'b1);
        next_drive();
        ifu_bus.ifu_req_valid = 1'b0;
        ifu_bus.ifu_rsp_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            ext_wr_valid = (s == 1);
            ext_wr_addr  = 12'd4;
            ext_wr_data  = 64'h5555_6666_7777_8888;
            ext_wr_mask  = 8'hFF;
            to_sample();
            chk($sformatf("stall%0d_valid", s), ifu_bus.ifu_rsp_valid, 1'b1);
            chk($sformatf("stall%0d_instr", s), ifu_bus.ifu_rsp_instr, old_word);
            if (ext_wr_valid) apply_write(4, ext_wr_data, ext_wr_mask);
            next_drive();
        end
        ext_wr_valid          = 1'b0;
        ifu_bus.ifu_rsp_ready = 1'b1;
        to_sample();
        chk("stall_release_instr", ifu_bus.ifu_rsp_instr, old_word);
        next_drive();
        set_req(32'h8000_0020, 1'b0);
        next_drive();
        ifu_bus.ifu_req_valid = 1'b0;
        to_sample();
        chk("stall_after_write_instr", ifu_bus.ifu_rsp_instr, 32'h7777_8888);
        next_drive();

        // Write priority and buffer coherence
        set_req(32'h8000_0030, 1'b0);
        next_drive();
        ifu_bus.ifu_req_valid = 1'b0;
        to_sample();
        chk("coh_first_instr", ifu_bus.ifu_rsp_instr, ref_rsp(32'h8000_0030).instr);
        next_drive();
        set_req(32'h8000_0034, 1'b1);
        ext_wr_valid = 1'b1;
        ext_wr_addr  = 12'd6;
        ext_wr_data  = 64'hDEAD_BEEF_0BAD_F00D;
        ext_wr_mask  = 8'hF0;
        to_sample();
        chk("wrprio_req_ready", ifu_bus.ifu_req_ready, 1'b0);
        chk("wrprio_wr_ready", ext_wr_ready, 1'b1);
        chk("wrprio_we", itcm_we, 1'b1);
        chk("wrprio_addr", itcm_addr, 12'd6);
        apply_write(6, ext_wr_data, ext_wr_mask);
        next_drive();
        ext_wr_valid = 1'b0;
        to_sample();
        chk("coh_blocked_no_rsp", ifu_bus.ifu_rsp_valid, 1'b0);
        chk("coh_reread_cs", itcm_cs, 1'b1);
        next_drive();
        ifu_bus.ifu_req_valid = 1'b0;
        to_sample();
        chk("coh_new_instr", ifu_bus.ifu_rsp_instr, 32'hDEAD_BEEF);
        next_drive();

        // Reset asserted mid-response
        set_req(32'h8000_0008, 1'b0);
        next_drive();
        ifu_bus.ifu_req_valid = 1'b0;
        ifu_bus.ifu_rsp_ready = 1'b0;
        to_sample();
        chk("midrst_pre_valid", ifu_bus.ifu_rsp_valid, 1'b1);
        next_drive();
        rst = 1'b1;
        next_drive();
        to_sample();
        chk("midrst_valid", ifu_bus.ifu_rsp_valid, 1'b0);
        chk("midrst_cs", itcm_cs, 1'b0);
        chk("midrst_instr", ifu_bus.ifu_rsp_instr, 32'h0);
        chk("midrst_err", ifu_bus.ifu_rsp_err, 1'b0);
        chk("midrst_req_ready", ifu_bus.ifu_req_ready, 1'b1);
        next_drive(); next_drive();
        rst = 1'b0;
        ifu_bus.ifu_rsp_ready = 1'b1;
        set_req(32'h8000_000C, 1'b1);
        to_sample();
        chk("postrst_lbuf_cleared_cs", itcm_cs, 1'b1);
        next_drive();
        set_req(32'h8000_0000, 1'b0);
        to_sample();
        chk("postrst_seq_instr", ifu_bus.ifu_rsp_instr, ref_rsp(32'h8000_000C).instr);
        next_drive();
        ifu_bus.ifu_req_valid = 1'b0;
        to_sample();
        chk("postrst_base_valid", ifu_bus.ifu_rsp_valid, 1'b1);
        chk("postrst_base_instr", ifu_bus.ifu_rsp_instr, 32'h1000_0000);
        next_drive();
        next_drive();

        // Randomized traffic against the reference model
        last_pc = BASE;
        for (int c = 0; c < 10000; c++) begin
            ext_wr_valid = ($urandom_range(0, 7) == 0);
            ext_wr_addr  = 12'($urandom_range(0, 15));
            ext_wr_data  = {$urandom, $urandom};
            ext_wr_mask  = 8'($urandom);
            ifu_bus.ifu_rsp_ready = ($urandom_range(0, 3) != 0);
            stalled = ifu_bus.ifu_rsp_valid && !ifu_bus.ifu_rsp_ready;
            ifu_bus.ifu_req_valid = !stalled && ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 19);
            if (sel < 12) begin
                pc = last_pc + 32'd4;
                ifu_bus.ifu_req_seq = 1'b1;
            end else if (sel < 18) begin
                pc = BASE + 32'($urandom_range(0, 15)) * 8 + 32'($urandom_range(0, 1)) * 4;
                ifu_bus.ifu_req_seq = 1'b0;
            end else begin
                case ($urandom_range(0, 3))
                    0:       pc = BASE + 32'($urandom_range(0, 127)) * 4 + 32'($urandom_range(1, 3));
                    1:       pc = 32'h9000_0000 + 32'($urandom_range(0, 255)) * 4;
                    2:       pc = BASE - 32'd4;
                    default: pc = LIMIT;
                endcase
                ifu_bus.ifu_req_seq = 1'b0;
            end
            ifu_bus.ifu_req_pc = pc;

            to_sample();
            chk("rnd_rsp_valid", ifu_bus.ifu_rsp_valid, exp_q.size() > 0);
            chk("rnd_req_ready", ifu_bus.ifu_req_ready, !ext_wr_valid);
            if (ifu_bus.ifu_rsp_valid && exp_q.size() > 0) begin
                chk("rnd_instr", ifu_bus.ifu_rsp_instr, exp_q[0].instr);
                chk("rnd_err", ifu_bus.ifu_rsp_err, exp_q[0].err);
                if (ifu_bus.ifu_rsp_ready) void'(exp_q.pop_front());
            end
            acc = ifu_bus.ifu_req_valid && !ext_wr_valid &&
                  (!ifu_bus.ifu_rsp_valid || ifu_bus.ifu_rsp_ready);
            if (acc) begin
                r = ref_rsp(pc);
                exp_q.push_back(r);
                last_pc = pc;
            end
            if (ext_wr_valid) apply_write(int'(ext_wr_addr), ext_wr_data, ext_wr_mask);
            next_drive();
        end

        // Drain: every accepted request must have been answered exactly once
        idle_inputs();
        for (int d = 0; d < 4 && exp_q.size() > 0; d++) begin
            to_sample();
            if (ifu_bus.ifu_rsp_valid) begin
                chk("drain_instr", ifu_bus.ifu_rsp_instr, exp_q[0].instr);
                void'(exp_q.pop_front());
            end
            next_drive();
        end
        to_sample();
        chk("drain_pending", exp_q.size(), 0);
        chk("drain_idle", ifu_bus.ifu_rsp_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
